// File: rtl/alu_seq.sv
// Operator front end for a 4-bit ALU: debounced button steps A -> B -> opcode -> execute -> show.
// Press latency DEB_CYCLES+3 clocks from a clean button edge; no backpressure, presses outside A/B/OP/SHOW are dropped.
module alu_seq #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_ctrl,
    input  logic [3:0] alu_res,
    input  logic       alu_car,
    input  logic       alu_of,
    output logic [3:0] res_q,
    output logic       car_q,
    output logic       of_q,
    output logic [2:0] state_o,
    output logic       done,
    output logic [7:0] op_cnt
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    logic        sync1_q;
    logic        sync2_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        btn_db_q;
    logic        btn_db_d;
    logic        btn_db_dly_q;
    logic        press;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  alu_a_q;
    logic [3:0]  alu_a_d;
    logic [3:0]  alu_b_q;
    logic [3:0]  alu_b_d;
    logic [2:0]  alu_ctrl_q;
    logic [2:0]  alu_ctrl_d;
    logic [3:0]  res_d;
    logic        car_d;
    logic        of_d;
    logic        done_q;
    logic        done_d;
    logic [7:0]  op_cnt_q;
    logic [7:0]  op_cnt_d;

    // Any return of the synchronized level to the debounced level restarts the qualification window.
    always_comb begin
        cnt_d    = '0;
        btn_db_d = btn_db_q;
        if (sync2_q != btn_db_q) begin
            if (cnt_q == DEB_CYCLES - 16'd1) begin
                btn_db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign press = btn_db_q & ~btn_db_dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            btn_db_q     <= 1'b0;
            btn_db_dly_q <= 1'b0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            btn_db_q     <= btn_db_d;
            btn_db_dly_q <= btn_db_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        res_d      = res_q;
        car_d      = car_q;
        of_d       = of_q;
        done_d     = 1'b0;
        op_cnt_d   = op_cnt_q;
        case (state_q)
            S_A: begin
                if (press) begin
                    alu_a_d = sw;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (press) begin
                    alu_b_d = sw;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (press) begin
                    alu_ctrl_d = sw[2:0];
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                // The ALU has had a full cycle to settle on the operands registered on entry.
                res_d    = alu_res;
                car_d    = alu_car;
                of_d     = alu_of;
                done_d   = 1'b1;
                op_cnt_d = op_cnt_q + 8'd1;
                state_d  = S_SHOW;
            end
            S_SHOW: begin
                if (press) begin
                    state_d = S_A;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            res_q      <= '0;
            car_q      <= 1'b0;
            of_q       <= 1'b0;
            done_q     <= 1'b0;
            op_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            res_q      <= res_d;
            car_q      <= car_d;
            of_q       <= of_d;
            done_q     <= done_d;
            op_cnt_q   <= op_cnt_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_ctrl = alu_ctrl_q;
    assign done     = done_q;
    assign op_cnt   = op_cnt_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU on the ALU port, press-level reference model, random operations.
module tb_alu_seq;

    localparam logic [15:0] DEB = 16'd4;
    localparam int          LOW = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw  = '0;
    logic       btn = 1'b0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_ctrl;
    logic [3:0] alu_res;
    logic       alu_car;
    logic       alu_of;
    logic [3:0] res_q;
    logic       car_q;
    logic       of_q;
    logic [2:0] state_o;
    logic       done;
    logic [7:0] op_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int         exp_state = 0;
    logic [3:0] exp_a     = '0;
    logic [3:0] exp_b     = '0;
    logic [2:0] exp_ctrl  = '0;
    logic [3:0] exp_res   = '0;
    logic       exp_car   = 1'b0;
    logic       exp_of    = 1'b0;
    logic [7:0] exp_cnt   = '0;
    int         exp_done  = 0;
    int         done_seen;

    always #5 clk = ~clk;

    function automatic logic [5:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [4:0] s;
        logic [3:0] r;
        logic       c;
        logic       o;
        s = '0;
        r = '0;
        c = 1'b0;
        o = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                c = s[4];
                o = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'd1: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[3:0];
                c = s[4];
                o = (a[3] != b[3]) && (r[3] != a[3]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = {a[2:0], 1'b0};
            default: r = {1'b0, a[3:1]};
        endcase
        return {o, c, r};
    endfunction

    assign {alu_of, alu_car, alu_res} = alu_ref(alu_a, alu_b, alu_ctrl);

    alu_seq #(.DEB_CYCLES(DEB)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .btn      (btn),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_ctrl (alu_ctrl),
        .alu_res  (alu_res),
        .alu_car  (alu_car),
        .alu_of   (alu_of),
        .res_q    (res_q),
        .car_q    (car_q),
        .of_q     (of_q),
        .state_o  (state_o),
        .done     (done),
        .op_cnt   (op_cnt)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) done_seen <= 0;
        else if (done) done_seen <= done_seen + 1;
    end

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_state"}, 16'(state_o), 16'(exp_state));
        chk({tag, "_a"}, 16'(alu_a), 16'(exp_a));
        chk({tag, "_b"}, 16'(alu_b), 16'(exp_b));
        chk({tag, "_ctrl"}, 16'(alu_ctrl), 16'(exp_ctrl));
        chk({tag, "_res"}, 16'({of_q, car_q, res_q}), 16'({exp_of, exp_car, exp_res}));
        chk({tag, "_cnt"}, 16'(op_cnt), 16'(exp_cnt));
    endtask

    // One clean press: button rises just after an edge, the FSM must move exactly DEB+3 edges later.
    task automatic press(input logic [3:0] v, input int hold);
        sw  = v;
        btn = 1'b1;
        repeat (int'(DEB) + 2) @(posedge clk);
        #1;
        chk("pre_press_state", 16'(state_o), 16'(exp_state));
        @(posedge clk);
        #1;
        case (exp_state)
            0: begin exp_a = v; exp_state = 1; end
            1: begin exp_b = v; exp_state = 2; end
            2: begin exp_ctrl = v[2:0]; exp_state = 3; end
            default: exp_state = 0;
        endcase
        chk_regs("press");
        if (exp_state == 3) begin
            chk("exec_done_low", 16'(done), 16'd0);
            @(posedge clk);
            #1;
            {exp_of, exp_car, exp_res} = alu_ref(exp_a, exp_b, exp_ctrl);
            exp_cnt++;
            exp_done++;
            exp_state = 4;
            chk_regs("capture");
            chk("done_pulse", 16'(done), 16'd1);
            @(posedge clk);
            #1;
            chk("done_drop", 16'(done), 16'd0);
            hold = hold - 2;
        end
        repeat (hold) @(posedge clk);
        #1;
        btn = 1'b0;
        repeat (LOW) @(posedge clk);
        #1;
        chk("after_release", 16'(state_o), 16'(exp_state));
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        exp_state = 0; exp_a = '0; exp_b = '0; exp_ctrl = '0;
        exp_res = '0; exp_car = 1'b0; exp_of = 1'b0; exp_cnt = '0; exp_done = 0;
        chk_regs("rst");
        chk("rst_done", 16'(done), 16'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 3 + 5 add: signed overflow into bit 3, no carry out.
        press(4'd3, 2);
        press(4'd5, 2);
        press(4'd0, 2);
        chk("add_res", 16'(res_q), 16'd8);
        chk("add_flags", 16'({car_q, of_q}), 16'b01);

        // Button held through EXEC and SHOW must yield one transition only.
        press(4'd0, 2);
        press(4'd12, 2);
        press(4'd7, 2);
        press(4'd1, 25);
        chk("held_show", 16'(state_o), 16'd4);
        press(4'd0, 2);

        // Bounce then a clean hold: one press.
        sw = 4'hA;
        for (int i = 0; i < 10; i++) begin
            btn = ~btn;
            @(posedge clk);
            #1;
        end
        btn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        exp_a = 4'hA;
        exp_state = 1;
        chk_regs("bounce");
        btn = 1'b0;
        repeat (LOW) @(posedge clk);
        #1;
        btn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        btn = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk_regs("glitch");

        press(4'd6, 2);
        press(4'd1, 2);
        press(4'd0, 2);
        press(4'd9, 2);
        chk("mid_a", 16'(alu_a), 16'd9);
        do_reset();
        chk("mid_done_total", 16'(done_seen), 16'd0);

        for (int k = 0; k < 256; k++) begin
            if (exp_state == 4) press(4'(($urandom)), 2);
            press(4'($urandom_range(0, 15)), 2);
            press(4'($urandom_range(0, 15)), 2);
            press(4'($urandom_range(0, 15)), 2);
            if (k == 254) chk("wrap_255", 16'(op_cnt), 16'd255);
            if (k == 255) chk("wrap_0", 16'(op_cnt), 16'd0);
        end
        chk("last_res", 16'({of_q, car_q, res_q}), 16'(alu_ref(exp_a, exp_b, exp_ctrl)));
        chk("done_total", 16'(done_seen), 16'(exp_done));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
